ram_rd_stream: RTL

Read-side streaming engine for a `ram_2p` instance in the same clock domain. It accepts a command giving a start address and a word count, then drives the RAM's port B (`enb`, `addrb`) and absorbs its one-cycle registered read latency. The words come out on a valid/ready stream, with full backpressure and no bubbles. It pairs with the producer that fills the RAM through port A and is what packet and descriptor readers use to drain RAM contents.

---
 rtl/ram_rd_stream.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ram_rd_stream.sv
// Streams words out of a ram_2p read port as a valid/ready beat sequence.
// A 2-entry skid FIFO absorbs the RAM's one-cycle read latency.
module ram_rd_stream #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]      doutb,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_addr_last;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic                  r_infl;
  logic                  r_infl_last;
  logic [WIDTH-1:0]      r_fdata [2];
  logic                  r_flast [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_cnt;
  logic [1:0]            w_slots;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_start;

  always_comb begin
    w_state_nx = r_state;
    w_pop      = (r_cnt != 2'd0) && out_ready;
    w_slots    = r_cnt + {1'b0, r_infl};
    w_start    = cmd_valid && (r_state == S_IDLE) && (cmd_len != '0);
    w_issue    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nx = S_READ;
      end
      S_READ: begin
        // A full slot count may still issue if the head leaves this cycle.
        w_issue = (r_rem != '0) &&
                  ((w_slots < 2'd2) || ((w_slots == 2'd2) && w_pop));
        if (w_issue && (r_rem == LEN_WIDTH'(1))) w_state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pop && r_flast[r_rptr]) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign w_addr_inc = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ?
                      '0 : r_addr + ADDR_WIDTH'(1);

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign enb       = w_issue;
  assign addrb     = w_issue ? r_addr : r_addr_last;
  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = r_fdata[r_rptr];
  assign out_last  = out_valid && r_flast[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_addr_last <= '0;
      r_rem       <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_cnt       <= 2'd0;
      r_fdata[0]  <= '0;
      r_fdata[1]  <= '0;
      r_flast[0]  <= 1'b0;
      r_flast[1]  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_start) begin
        r_addr <= cmd_addr;
        r_rem  <= cmd_len;
      end else if (w_issue) begin
        r_addr      <= w_addr_inc;
        r_addr_last <= r_addr;
        r_rem       <= r_rem - LEN_WIDTH'(1);
      end
      r_infl      <= w_issue;
      r_infl_last <= w_issue && (r_rem == LEN_WIDTH'(1));
      if (r_infl) begin
        r_fdata[r_wptr] <= doutb;
        r_flast[r_wptr] <= r_infl_last;
        r_wptr          <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
    end
  end

endmodule
